// File: rtl/ripple_count_monitor.sv
// Monitors an asynchronous 3-bit up/down ripple counter: synchronizes and deglitches its outputs,
// then checks every accepted step against the counter mode and flags wraps and bad steps.
module ripple_count_monitor #(
    parameter int unsigned STABLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] q_in,
    input  logic       m,
    input  logic       en,
    output logic [2:0] count_out,
    output logic       valid,
    output logic       step_err,
    output logic       wrap,
    output logic [7:0] err_cnt
);

    localparam logic [3:0] StableMax = 4'(STABLE_CYC);
    localparam logic [3:0] StableThr = 4'(STABLE_CYC - 1);
    localparam logic [1:0] FillDone  = 2'd2;

    typedef enum logic [0:0] {
        StInit,
        StTrack
    } state_e;

    logic [2:0] q_s1_q, q_s2_q;
    logic       m_s1_q, m_s2_q;
    logic [1:0] fill_q, fill_d;
    logic [3:0] stab_q, stab_d;
    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       valid_q, valid_d;
    logic       step_err_q, step_err_d;
    logic       wrap_q, wrap_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       sync_full;
    logic       stable;
    logic [2:0] expected;

    // Synchronizer contents only become meaningful two edges after reset, so the
    // reset zeros are never mistaken for a stable counter value.
    assign sync_full = (fill_q == FillDone);

    always_comb begin
        fill_d = fill_q;
        if (!sync_full) begin
            fill_d = fill_q + 2'd1;
        end
    end

    // stab_q counts edges s_q has held beyond the one on which it changed.
    always_comb begin
        stab_d = stab_q;
        if (!en || !sync_full || (q_s1_q != q_s2_q)) begin
            stab_d = '0;
        end else if (stab_q != StableMax) begin
            stab_d = stab_q + 4'd1;
        end
    end

    assign stable   = en && sync_full && (stab_q >= StableThr);
    assign expected = m_s2_q ? (count_q + 3'd1) : (count_q - 3'd1);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        valid_d    = 1'b0;
        step_err_d = 1'b0;
        wrap_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        if (!en) begin
            state_d = StInit;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (stable) begin
                        count_d = q_s2_q;
                        valid_d = 1'b1;
                        state_d = StTrack;
                    end
                end
                StTrack: begin
                    if (stable && (q_s2_q != count_q)) begin
                        count_d = q_s2_q;
                        valid_d = 1'b1;
                        if (q_s2_q != expected) begin
                            step_err_d = 1'b1;
                            if (err_cnt_q != 8'hFF) begin
                                err_cnt_d = err_cnt_q + 8'd1;
                            end
                        end else if ((m_s2_q && (count_q == 3'd7)) ||
                                     (!m_s2_q && (count_q == 3'd0))) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_s1_q     <= '0;
            q_s2_q     <= '0;
            m_s1_q     <= 1'b0;
            m_s2_q     <= 1'b0;
            fill_q     <= '0;
            stab_q     <= '0;
            state_q    <= StInit;
            count_q    <= '0;
            valid_q    <= 1'b0;
            step_err_q <= 1'b0;
            wrap_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            q_s1_q     <= q_in;
            q_s2_q     <= q_s1_q;
            m_s1_q     <= m;
            m_s2_q     <= m_s1_q;
            fill_q     <= fill_d;
            stab_q     <= stab_d;
            state_q    <= state_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            step_err_q <= step_err_d;
            wrap_q     <= wrap_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign count_out = count_q;
    assign valid     = valid_q;
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with STABLE_CYC=2: latency, stepping, wrap,
// glitch filtering, enable, error saturation and mid-run reset.
module tb_ripple_count_monitor;

    logic       clk;
    logic       rst_n;
    logic [2:0] q_in;
    logic       m;
    logic       en;
    logic [2:0] count_out;
    logic       valid;
    logic       step_err;
    logic       wrap;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    // Pulse tallies, written only by the monitor below.
    int n_valid = 0;
    int n_err   = 0;
    int n_wrap  = 0;

    int v0, e0, w0;

    ripple_count_monitor #(
        .STABLE_CYC(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q_in     (q_in),
        .m        (m),
        .en       (en),
        .count_out(count_out),
        .valid    (valid),
        .step_err (step_err),
        .wrap     (wrap),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) n_valid++;
        if (step_err === 1'b1) n_err++;
        if (wrap === 1'b1) n_wrap++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_q(input logic [2:0] v, input int n);
        q_in = v;
        tick(n);
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
        w0 = n_wrap;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        m     = 1'b1;
        q_in  = 3'd0;
        tick(3);
        chk("rst_count", 32'(count_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_step_err", 32'(step_err), 0);
        chk("rst_wrap", 32'(wrap), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);

        // First acceptance after reset: valid exactly STABLE_CYC+2 edges after settling.
        snap();
        rst_n = 1'b1;
        en    = 1'b1;
        q_in  = 3'd3;
        tick(1);
        chk("lat_edge0", 32'(valid), 0);
        tick(1);
        chk("lat_edge1", 32'(valid), 0);
        tick(1);
        chk("lat_edge2", 32'(valid), 0);
        tick(1);
        chk("lat_edge3", 32'(valid), 1);
        chk("lat_count", 32'(count_out), 3);
        chk("lat_step_err", 32'(step_err), 0);
        tick(1);
        chk("lat_pulse_end", 32'(valid), 0);
        tick(5);
        chk("lat_valid_once", 32'(n_valid - v0), 1);

        // Up stepping with one wrap on 7->0.
        snap();
        set_q(3'd4, 10);
        set_q(3'd5, 10);
        set_q(3'd6, 10);
        set_q(3'd7, 10);
        chk("up_no_early_wrap", 32'(n_wrap - w0), 0);
        set_q(3'd0, 10);
        chk("up_valids", 32'(n_valid - v0), 5);
        chk("up_step_err", 32'(n_err - e0), 0);
        chk("up_wrap", 32'(n_wrap - w0), 1);
        chk("up_err_cnt", 32'(err_cnt), 0);
        chk("up_count", 32'(count_out), 0);

        set_q(3'd1, 10);
        set_q(3'd2, 10);
        chk("up_count2", 32'(count_out), 2);

        // Mode change alone produces nothing.
        snap();
        m = 1'b0;
        tick(6);
        chk("mode_only_valid", 32'(n_valid - v0), 0);
        chk("mode_only_err", 32'(n_err - e0), 0);
        chk("mode_only_wrap", 32'(n_wrap - w0), 0);

        // Down stepping with wrap on 0->7, then a bad step 7->5.
        set_q(3'd1, 10);
        set_q(3'd0, 10);
        set_q(3'd7, 10);
        chk("dn_valids", 32'(n_valid - v0), 3);
        chk("dn_wrap", 32'(n_wrap - w0), 1);
        chk("dn_step_err", 32'(n_err - e0), 0);
        snap();
        set_q(3'd5, 10);
        chk("bad_step_err", 32'(n_err - e0), 1);
        chk("bad_wrap", 32'(n_wrap - w0), 0);
        chk("bad_err_cnt", 32'(err_cnt), 1);
        chk("bad_count", 32'(count_out), 5);

        // Back to 3 going down, then switch to up and glitch through 2 and 0 to 4.
        set_q(3'd4, 10);
        set_q(3'd3, 10);
        m = 1'b1;
        tick(6);
        snap();
        set_q(3'd2, 1);
        set_q(3'd0, 1);
        set_q(3'd4, 10);
        chk("glitch_valids", 32'(n_valid - v0), 1);
        chk("glitch_step_err", 32'(n_err - e0), 0);
        chk("glitch_count", 32'(count_out), 4);

        // Enable dropped: everything frozen; raised on 6: reload without checking.
        snap();
        en = 1'b0;
        set_q(3'd5, 10);
        chk("dis_valid", 32'(n_valid - v0), 0);
        chk("dis_err", 32'(n_err - e0), 0);
        chk("dis_count", 32'(count_out), 4);
        set_q(3'd6, 4);
        en = 1'b1;
        tick(10);
        chk("ena_valids", 32'(n_valid - v0), 1);
        chk("ena_step_err", 32'(n_err - e0), 0);
        chk("ena_count", 32'(count_out), 6);
        chk("ena_err_cnt", 32'(err_cnt), 1);

        // Saturate err_cnt with +2 steps under up mode.
        snap();
        for (int i = 0; i < 254; i++) begin
            set_q(q_in + 3'd2, 5);
        end
        chk("sat_err_pulses", 32'(n_err - e0), 254);
        chk("sat_err_cnt", 32'(err_cnt), 255);
        chk("sat_count", 32'(count_out), 2);
        snap();
        set_q(3'd4, 8);
        chk("sat_more_pulse", 32'(n_err - e0), 1);
        chk("sat_hold", 32'(err_cnt), 255);

        // A bad 7->0 step in down mode must not be reported as a wrap.
        set_q(3'd5, 8);
        set_q(3'd6, 8);
        set_q(3'd7, 8);
        m = 1'b0;
        tick(6);
        snap();
        set_q(3'd0, 8);
        chk("badwrap_err", 32'(n_err - e0), 1);
        chk("badwrap_wrap", 32'(n_wrap - w0), 0);
        chk("badwrap_count", 32'(count_out), 0);

        // Reset mid-operation discards the pending value.
        set_q(3'd1, 2);
        rst_n = 1'b0;
        tick(2);
        chk("mid_rst_count", 32'(count_out), 0);
        chk("mid_rst_err_cnt", 32'(err_cnt), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        snap();
        rst_n = 1'b1;
        tick(10);
        chk("post_rst_valids", 32'(n_valid - v0), 1);
        chk("post_rst_err", 32'(n_err - e0), 0);
        chk("post_rst_count", 32'(count_out), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 2 (range 1-15): consecutive synchronized cycles a counter value must hold before it is accepted.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port q_in, input, 3: asynchronous up/down ripple counter outputs {q3,q2,q1}, q3 MSB.
REQ-005 SHALL have port m, input, 1: counter mode, 1 = up, 0 = down; asynchronous to clk.
REQ-006 SHALL have port en, input, 1: monitor enable.
REQ-007 SHALL have port count_out, output, 3: last accepted counter value.
REQ-008 SHALL have port valid, output, 1: one-cycle pulse when count_out is updated.
REQ-009 SHALL have port step_err, output, 1: one-cycle pulse when an accepted step does not match mode m.
REQ-010 SHALL have port wrap, output, 1: one-cycle pulse on a correct 7->0 step (up) or 0->7 step (down).
REQ-011 SHALL have port err_cnt, output, 8: saturating count of step_err pulses.

Function
REQ-012 SHALL pass q_in and m each through a two-flop synchronizer; s_q and s_m denote the second-flop outputs.
REQ-013 SHALL keep a stability counter: cleared when s_q differs from its previous-cycle value, otherwise incremented, saturating at STABLE_CYC.
REQ-014 SHALL treat s_q as stable once it has held one value for STABLE_CYC consecutive edges, which filters ripple glitches.
REQ-015 SHALL implement FSM states INIT (no reference value) and TRACK.
REQ-016 In INIT with en=1, the first stable value SHALL be loaded into count_out with valid pulsed, no step check, and the next state TRACK.
REQ-017 In TRACK, a stable value different from count_out SHALL be loaded into count_out and valid pulsed in that same cycle.
REQ-018 For each TRACK acceptance, expected = (count_out + 1) mod 8 if s_m=1, else (count_out - 1) mod 8, using s_m sampled in the accepting cycle.
REQ-019 On acceptance with new value != expected: step_err SHALL pulse, err_cnt SHALL increment (hold at 255), and wrap SHALL stay 0.
REQ-020 On acceptance with new value == expected and (old,new) = (7,0) for up or (0,7) for down: wrap SHALL pulse.
REQ-021 A stable value equal to count_out SHALL produce no valid, step_err or wrap.
REQ-022 Each value change SHALL be accepted at most once, with no re-triggering while the value stays stable.
REQ-023 Latency: if q_in settles before edge N, valid SHALL be high in the cycle after edge N+STABLE_CYC+1, i.e. STABLE_CYC+2 edges later.
REQ-024 A q_in change arriving before the previous value is accepted SHALL restart the stability count; only the final value is accepted.
REQ-025 en=0 SHALL force state INIT, clear the stability counter, hold count_out and err_cnt, and hold valid/step_err/wrap at 0; the synchronizers keep running.
REQ-026 A change of m SHALL only affect the expected value of acceptances after s_m reflects it; a mode change alone SHALL produce no pulse.
REQ-027 valid, step_err and wrap SHALL be registered outputs, each high for exactly one cycle per event.

Reset
REQ-028 With rst_n=0 at a rising edge: count_out=0, valid=0, step_err=0, wrap=0, err_cnt=0, synchronizer flops=0, stability counter=0, state=INIT.
REQ-029 Reset SHALL take priority over en and all other inputs.
REQ-030 Reset asserted mid-operation SHALL discard any pending value; after release, the first stable value is handled per REQ-016.

Verification
REQ-031 Reset release, en=1, q_in=3 held, STABLE_CYC=2 -> valid pulses once 4 edges after q_in settles, count_out=3, step_err=0.
REQ-032 m=1, q_in stepped 3,4,5,6,7,0 with 10 clocks per step -> 5 valid pulses, no step_err, one wrap on 7->0, err_cnt=0.
REQ-033 m=0, q_in stepped 2,1,0,7 -> wrap pulses once on 0->7; then q_in 7->5 -> step_err pulse, err_cnt=1, count_out=5.
REQ-034 From count_out=3 with m=1, q_in glitches 3->2->0->4 with each intermediate held 1 cycle -> single valid with count_out=4, no step_err.
REQ-035 err_cnt preset to 255 by 255 bad steps, then a further bad step -> step_err pulses, err_cnt stays 255.
REQ-036 en dropped mid-run -> no pulses and count_out held; en raised with q_in=6 -> INIT reload to 6, valid pulses, no step_err.
